// File: rtl/egd_pkg.sv
// Shared types for the Exp-Golomb bitstream decoder.
package egd_pkg;

  typedef enum logic [1:0] {
    EGD_UE = 2'd0,
    EGD_SE = 2'd1,
    EGD_TE = 2'd2,
    EGD_U  = 2'd3
  } egd_mode_e;

  typedef enum logic [1:0] {
    StFill = 2'd0,
    StEmit = 2'd1,
    StErr  = 2'd2
  } egd_state_e;

  localparam int unsigned SymLenW = 6;
  localparam int unsigned SymCntW = 16;

endpackage

// File: rtl/egd_lzc.sv
// Combinational leading-zero counter; lz_o equals Width when every bit is zero.
module egd_lzc #(
  parameter int unsigned Width = 16,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] bits_i,
  output logic [CntW-1:0]  lz_o,
  output logic             all_zero_o
);

  // Scan LSB to MSB so the highest set bit has the final say.
  always_comb begin
    lz_o = CntW'(Width);
    for (int unsigned i = 0; i < Width; i++) begin
      if (bits_i[i]) lz_o = CntW'(Width - 1 - i);
    end
  end

  assign all_zero_o = ~|bits_i;

endmodule

// File: rtl/egd_stream_decoder.sv
// Exp-Golomb / fixed-length symbol decoder over an MSB-aligned bit buffer.
module egd_stream_decoder
  import egd_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned BUF_W  = 64,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned MAX_LZ = 15,
  localparam int unsigned FillW = $clog2(BUF_W + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic               te_gt1,
  input  logic [4:0]         fixed_len,
  output logic [OUT_W-1:0]   sym_data,
  output logic [SymLenW-1:0] sym_len,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic               err,
  output logic [FillW-1:0]   fill_level,
  output logic [SymCntW-1:0] sym_count
);

  localparam int unsigned HeadW = MAX_LZ + 1;
  localparam int unsigned LzW   = $clog2(MAX_LZ + 2);
  localparam int unsigned CodeW = 2 * MAX_LZ + 1;

  egd_state_e          state_q;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [FillW-1:0]    fill_q, fill_d;
  logic [OUT_W-1:0]    sym_data_q;
  logic [SymLenW-1:0]  sym_len_q;
  logic                sym_valid_q;
  logic [SymCntW-1:0]  cnt_q;

  egd_mode_e           mode_e;
  logic [LzW-1:0]      lz;
  logic                all_zero;
  logic [SymLenW-1:0]  need;
  logic [SymLenW-1:0]  head_sh;
  logic                go_err, can_emit, take, accept;
  logic [FillW-1:0]    shamt, kept;
  logic [CodeW-1:0]    code_field, code_num;
  logic [OUT_W-1:0]    se_half, dec_data;
  logic [BUF_W-1:0]    word_ext;
  logic                unused_code;

  egd_lzc #(
    .Width(HeadW),
    .CntW (LzW)
  ) u_lzc (
    .bits_i    (buf_q[BUF_W-1 -: HeadW]),
    .lz_o      (lz),
    .all_zero_o(all_zero)
  );

  assign mode_e   = egd_mode_e'(mode);
  assign in_ready = reset_n && !flush && (state_q != StErr) &&
                    (fill_q <= FillW'(BUF_W - IN_W));
  assign accept   = in_valid && in_ready;

  always_comb begin
    unique case (mode_e)
      EGD_TE:  need = te_gt1 ? SymLenW'({lz, 1'b1}) : SymLenW'(1);
      EGD_U:   need = SymLenW'(fixed_len);
      default: need = SymLenW'({lz, 1'b1});
    endcase
  end

  // An all-zero head can only be legal for fixed-length reads.
  assign go_err   = (mode_e != EGD_U) && all_zero && (fill_q >= FillW'(HeadW));
  assign can_emit = fill_q >= FillW'(need);
  assign take     = (state_q == StFill) && !go_err && can_emit;

  // The top `need` bits read as an integer are 2^lz + info, so codeNum is that minus one.
  always_comb begin
    head_sh    = SymLenW'(CodeW) - need;
    code_field = buf_q[BUF_W-1 -: CodeW] >> head_sh;
    code_num   = code_field - CodeW'(1);
    se_half    = code_num[OUT_W:1];
    dec_data   = code_num[OUT_W-1:0];
    unique case (mode_e)
      EGD_SE:  dec_data = code_num[0] ? se_half + OUT_W'(1) : OUT_W'(0) - se_half;
      EGD_TE:  if (!te_gt1) dec_data = {{(OUT_W-1){1'b0}}, ~buf_q[BUF_W-1]};
      EGD_U:   dec_data = code_field[OUT_W-1:0];
      default: dec_data = code_num[OUT_W-1:0];
    endcase
  end

  assign unused_code = ^code_num[CodeW-1:OUT_W+1];

  always_comb begin
    shamt    = take ? FillW'(need) : '0;
    kept     = fill_q - shamt;
    word_ext = {in_data, {(BUF_W-IN_W){1'b0}}} >> kept;
    buf_d    = buf_q << shamt;
    fill_d   = kept;
    if (accept) begin
      buf_d  = buf_d | word_ext;
      fill_d = kept + FillW'(IN_W);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state_q     <= StFill;
      buf_q       <= '0;
      fill_q      <= '0;
      sym_data_q  <= '0;
      sym_len_q   <= '0;
      sym_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      unique case (state_q)
        StFill: begin
          if (go_err) begin
            state_q <= StErr;
          end else if (can_emit) begin
            state_q     <= StEmit;
            sym_data_q  <= dec_data;
            sym_len_q   <= need;
            sym_valid_q <= 1'b1;
          end
        end
        StEmit: begin
          if (sym_ready) begin
            state_q     <= StFill;
            sym_valid_q <= 1'b0;
            cnt_q       <= cnt_q + SymCntW'(1);
          end
        end
        StErr:   state_q <= StErr;
        default: state_q <= StFill;
      endcase
    end
  end

  assign sym_data   = sym_data_q;
  assign sym_len    = sym_len_q;
  assign sym_valid  = sym_valid_q;
  assign err        = (state_q == StErr);
  assign fill_level = fill_q;
  assign sym_count  = cnt_q;

endmodule

// File: tb/tb_egd_stream_decoder.sv
// Bench: bit-queue reference model checked every cycle, plus literal decode cases.
module tb_egd_stream_decoder;

  localparam int IN_W   = 16;
  localparam int BUF_W  = 64;
  localparam int OUT_W  = 16;
  localparam int MAX_LZ = 15;
  localparam int FW     = $clog2(BUF_W + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       mode = 2'd0;
  logic             te_gt1 = 1'b0;
  logic [4:0]       fixed_len = 5'd1;
  logic [OUT_W-1:0] sym_data;
  logic [5:0]       sym_len;
  logic             sym_valid;
  logic             sym_ready = 1'b0;
  logic             err;
  logic [FW-1:0]    fill_level;
  logic [15:0]      sym_count;

  always #5 clk = ~clk;

  egd_stream_decoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .te_gt1    (te_gt1),
    .fixed_len (fixed_len),
    .sym_data  (sym_data),
    .sym_len   (sym_len),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .err       (err),
    .fill_level(fill_level),
    .sym_count (sym_count)
  );

  // Reference model: buffered bits as a queue, head first.
  bit               mq[$];
  int               m_st;  // 0 fill, 1 emit, 2 err
  logic [OUT_W-1:0] m_data;
  int               m_len;
  bit               m_valid;
  int               m_cnt;

  int vectors = 0;
  int n_cmp = 0;
  int miscompares = 0;

  logic [OUT_W-1:0] dut_sym[$];
  int               dut_len[$];

  int ue_exp[4] = '{0, 1, 2, 3};
  int se_exp[4] = '{0, 1, 16'hFFFF, 2};
  int eg_len[4] = '{1, 3, 3, 5};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit exp_ready();
    return (reset_n === 1'b1) && (flush === 1'b0) && (mq.size() <= BUF_W - IN_W) && (m_st != 2);
  endfunction

  task automatic model_step();
    bit acc, found, ok;
    int lz, need, info, k;
    logic [OUT_W-1:0] v;
    acc = (in_valid === 1'b1) && exp_ready();
    if (reset_n !== 1'b1 || flush === 1'b1) begin
      mq.delete();
      m_st = 0; m_data = '0; m_len = 0; m_valid = 0; m_cnt = 0;
      return;
    end
    if (m_st == 1) begin
      if (sym_ready) begin
        m_st = 0; m_valid = 0; m_cnt = (m_cnt + 1) % 65536;
      end
    end else if (m_st == 0) begin
      found = 0; lz = 0; ok = 0; v = '0; need = 0;
      for (int i = 0; i < mq.size(); i++) begin
        if (!found) begin
          if (mq[i]) found = 1;
          else lz++;
        end
      end
      if (mode != 2'd3 && mq.size() >= MAX_LZ + 1 && lz >= MAX_LZ + 1) begin
        m_st = 2;
      end else begin
        if (mode == 2'd3) begin
          need = int'(fixed_len);
          if (mq.size() >= need) begin
            ok = 1;
            for (int i = 0; i < need; i++) v = OUT_W'((int'(v) << 1) | int'(mq[i]));
          end
        end else if (mode == 2'd2 && !te_gt1) begin
          need = 1;
          if (mq.size() >= 1) begin
            ok = 1; v = OUT_W'(!mq[0]);
          end
        end else begin
          need = 2 * lz + 1;
          if (found && mq.size() >= need) begin
            ok = 1; info = 0;
            for (int i = 0; i < lz; i++) info = info * 2 + int'(mq[lz + 1 + i]);
            k = (1 << lz) - 1 + info;
            if (mode == 2'd1) v = (k % 2 == 1) ? OUT_W'((k + 1) / 2) : OUT_W'(-(k / 2));
            else v = OUT_W'(k);
          end
        end
        if (ok) begin
          m_data = v; m_len = need; m_valid = 1; m_st = 1;
          repeat (need) void'(mq.pop_front());
        end
      end
    end
    if (acc) for (int i = IN_W - 1; i >= 0; i--) mq.push_back(in_data[i]);
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    vectors++;
    chk("in_ready", in_ready, exp_ready());
    chk("sym_valid", sym_valid, m_valid);
    chk("err", err, m_st == 2);
    chk("fill_level", fill_level, mq.size());
    chk("sym_count", sym_count, m_cnt);
    chk("sym_data", sym_data, m_data);
    chk("sym_len", sym_len, m_len);
    if (sym_valid === 1'b1 && sym_ready === 1'b1) begin
      dut_sym.push_back(sym_data);
      dut_len.push_back(int'(sym_len));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [1:0] m, input logic t, input logic [4:0] n,
                          input logic [15:0] w, input int want, input string tag);
    flush = 1'b1; in_valid = 1'b0; tick(); flush = 1'b0;
    mode = m; te_gt1 = t; fixed_len = n; sym_ready = 1'b1;
    dut_sym.delete(); dut_len.delete();
    in_data = w; in_valid = 1'b1; tick(); in_valid = 1'b0;
    for (int i = 0; i < 40 && dut_sym.size() < want; i++) tick();
    chk({tag, "_got_syms"}, dut_sym.size() >= want, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_fill", fill_level, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", sym_valid, 0);
    reset_n = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1);

    run_word(2'd0, 1'b0, 5'd1, 16'hA640, 4, "ue");
    repeat (3) tick();
    chk("ue_count", dut_sym.size(), 4);
    if (dut_sym.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ue_sym%0d", i), dut_sym[i], ue_exp[i]);
        chk($sformatf("ue_len%0d", i), dut_len[i], eg_len[i]);
      end
    chk("ue_fill", fill_level, 4);

    run_word(2'd1, 1'b0, 5'd1, 16'hA640, 4, "se");
    if (dut_sym.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("se_sym%0d", i), dut_sym[i], se_exp[i]);

    run_word(2'd2, 1'b0, 5'd1, 16'h4000, 2, "te");
    if (dut_sym.size() >= 2) begin
      chk("te_sym0", dut_sym[0], 1);
      chk("te_sym1", dut_sym[1], 0);
      chk("te_len0", dut_len[0], 1);
      chk("te_len1", dut_len[1], 1);
    end

    run_word(2'd3, 1'b0, 5'd5, 16'hF800, 1, "u5");
    if (dut_sym.size() >= 1) begin
      chk("u5_sym", dut_sym[0], 31);
      chk("u5_len", dut_len[0], 5);
    end

    // Overlong prefix
    flush = 1'b1; tick(); flush = 1'b0;
    mode = 2'd0; in_data = 16'h0000; in_valid = 1'b1;
    tick();
    chk("err_early", err, 0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("err_set", err, 1);
    chk("err_ready", in_ready, 0);
    flush = 1'b1; in_valid = 1'b1; tick(); flush = 1'b0; in_valid = 1'b0;
    chk("err_clear", err, 0);
    chk("err_flush_fill", fill_level, 0);

    // Back-pressure on the output
    mode = 2'd0; sym_ready = 1'b0; in_data = 16'hA640; in_valid = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", sym_valid, 1);
      chk("stall_data", sym_data, 0);
      chk("stall_len", sym_len, 1);
      tick();
    end
    chk("stall_ready", in_ready, 0);
    chk("stall_fill", fill_level, 63);
    chk("stall_cnt0", sym_count, 0);
    sym_ready = 1'b1; tick(); sym_ready = 1'b0; in_valid = 1'b0;
    chk("stall_cnt1", sym_count, 1);
    tick(); tick();
    chk("stall_cnt_hold", sym_count, 1);
    chk("emit_again", sym_valid, 1);

    // Reset while a symbol is pending
    reset_n = 1'b0; sym_ready = 1'b1; tick();
    chk("rst_emit_valid", sym_valid, 0);
    chk("rst_emit_cnt", sym_count, 0);
    chk("rst_emit_fill", fill_level, 0);
    chk("rst_emit_data", sym_data, 0);
    reset_n = 1'b1;
    #1;
    chk("rst_emit_ready", in_ready, 1);

    for (int c = 0; c < 4000; c++) begin
      mode      = 2'($urandom_range(3, 0));
      te_gt1    = 1'($urandom_range(1, 0));
      fixed_len = 5'($urandom_range(16, 1));
      sym_ready = ($urandom_range(3, 0) != 0);
      in_valid  = ($urandom_range(1, 0) == 1);
      case ($urandom_range(3, 0))
        0:       in_data = 16'($urandom & $urandom & $urandom & $urandom);
        1:       in_data = 16'($urandom & $urandom);
        default: in_data = 16'($urandom);
      endcase
      flush   = ($urandom_range(149, 0) == 0);
      reset_n = ($urandom_range(599, 0) != 0);
      tick();
    end
    flush = 1'b0; reset_n = 1'b1; in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
